// File: rtl/xm23_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | xm23_pkg : shared constants and types for the xm23 PIC          |
// | Rev 1.0  : initial release                                      |
// +-----------------------------------------------------------------+
package xm23_pkg;

    localparam int CSR_IE  = 0;
    localparam int CSR_IO  = 1;
    localparam int CSR_DBA = 2;
    localparam int CSR_OF  = 3;

    localparam int PRI_W  = 3;
    localparam int VECT_W = 4;

    localparam int PIC_VALID_BIT = 7;
    localparam int PIC_PRI_LSB   = 4;
    localparam int PIC_VECT_LSB  = 0;

    localparam int DEV_TMR = 0;
    localparam int DEV_KB  = 1;
    localparam int DEV_SCR = 2;
    localparam int DEV_TL  = 3;
    localparam int DEV_PB  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } pic_state_t;

    function automatic logic [7:0] make_pic_out(input logic [PRI_W-1:0] pri,
                                                input logic [VECT_W-1:0] vect);
        logic [7:0] r;
        r = '0;
        r[PIC_VALID_BIT]              = 1'b1;
        r[PIC_PRI_LSB +: PRI_W]       = pri;
        r[PIC_VECT_LSB +: VECT_W]     = vect;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xm23_pic_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | xm23_pic_if : device CSR / CPU bus bundle for the xm23 PIC      |
// | Rev 1.0  : initial release                                      |
// +-----------------------------------------------------------------+
interface xm23_pic_if #(
    parameter int NUM_DEV = 5
);
    logic [8*NUM_DEV-1:0] dev_csr;
    logic [3*NUM_DEV-1:0] dev_pri;
    logic [2:0]           cpu_pri;
    logic                 pic_read;
    logic [7:0]           pic_out;
    logic [NUM_DEV-1:0]   dev_ack;
    logic [NUM_DEV-1:0]   pend_o;

    // CPU/device side
    modport master (
        output dev_csr, dev_pri, cpu_pri, pic_read,
        input  pic_out, dev_ack, pend_o
    );

    // Controller side
    modport slave (
        input  dev_csr, dev_pri, cpu_pri, pic_read,
        output pic_out, dev_ack, pend_o
    );
endinterface
`default_nettype wire

// File: rtl/pic_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pic_arbiter : highest-priority pending device, lowest index     |
// | Rev 1.0  : initial release                                      |
// +-----------------------------------------------------------------+
module pic_arbiter
    import xm23_pkg::*;
#(
    parameter int NUM_DEV = 5
) (
    input  logic [NUM_DEV-1:0]       pending,
    input  logic [PRI_W*NUM_DEV-1:0] dev_pri,
    output logic [VECT_W-1:0]        win_idx,
    output logic [PRI_W-1:0]         win_pri,
    output logic                     any
);

    // Strict '>' keeps the earlier (lower) index on equal priority.
    always_comb begin
        win_idx = '0;
        win_pri = '0;
        any     = 1'b0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (pending[i] && (!any || (dev_pri[PRI_W*i +: PRI_W] > win_pri))) begin
                any     = 1'b1;
                win_pri = dev_pri[PRI_W*i +: PRI_W];
                win_idx = VECT_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/xm23_pic.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | xm23_pic : priority interrupt controller, CSR DBA edges -> CPU  |
// | Rev 1.0  : initial release                                      |
// +-----------------------------------------------------------------+
module xm23_pic
    import xm23_pkg::*;
#(
    parameter int NUM_DEV = 5
) (
    input  logic        Clock,
    input  logic        Reset_n,
    xm23_pic_if.slave   bus
);

    logic [NUM_DEV-1:0] ie;
    logic [NUM_DEV-1:0] dba;
    logic [NUM_DEV-1:0] dba_prev;
    logic [NUM_DEV-1:0] rise;
    logic [NUM_DEV-1:0] pending;
    logic [NUM_DEV-1:0] clr;
    logic [NUM_DEV-1:0] sel_onehot;
    logic [NUM_DEV-1:0] dev_ack_q;
    logic [NUM_DEV-1:0] dev_ack_d;
    logic [VECT_W-1:0]  sel;
    logic [VECT_W-1:0]  sel_d;
    logic [VECT_W-1:0]  win_idx;
    logic [PRI_W-1:0]   win_pri;
    logic [PRI_W-1:0]   sel_pri;
    logic               win_any;
    logic               eligible;
    logic [7:0]         pic_out_q;
    logic [7:0]         pic_out_d;
    pic_state_t         state;
    pic_state_t         next_state;

    // IO and OF bits are carried on the bus but play no part here.
    logic unused_csr;
    assign unused_csr = ^bus.dev_csr;

    for (genvar i = 0; i < NUM_DEV; i++) begin : g_dev
        assign ie[i]         = bus.dev_csr[8*i + CSR_IE];
        assign dba[i]        = bus.dev_csr[8*i + CSR_DBA];
        assign sel_onehot[i] = (sel == VECT_W'(i));
    end

    assign rise = dba & ~dba_prev & ie;

    pic_arbiter #(
        .NUM_DEV (NUM_DEV)
    ) u_arb (
        .pending (pending),
        .dev_pri (bus.dev_pri),
        .win_idx (win_idx),
        .win_pri (win_pri),
        .any     (win_any)
    );

    assign eligible = win_any && (win_pri > bus.cpu_pri);

    always_comb begin
        sel_pri = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (sel == VECT_W'(i)) begin
                sel_pri = bus.dev_pri[PRI_W*i +: PRI_W];
            end
        end
    end

    always_comb begin
        next_state = state;
        pic_out_d  = pic_out_q;
        dev_ack_d  = '0;
        sel_d      = sel;
        clr        = '0;
        unique case (state)
            ST_IDLE: begin
                if (eligible) begin
                    next_state = ST_REQ;
                    sel_d      = win_idx;
                    pic_out_d  = make_pic_out(win_pri, win_idx);
                end
            end
            ST_REQ: begin
                if (bus.pic_read) begin
                    next_state = ST_ACK;
                    clr        = sel_onehot;
                    dev_ack_d  = sel_onehot;
                    pic_out_d  = '0;
                end else if (sel_pri <= bus.cpu_pri) begin
                    // Withdraw only: the device stays pending for later.
                    next_state = ST_IDLE;
                    pic_out_d  = '0;
                end
            end
            ST_ACK: begin
                if (!bus.pic_read) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
                pic_out_d  = '0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            dba_prev  <= '0;
            pending   <= '0;
            pic_out_q <= '0;
            dev_ack_q <= '0;
            sel       <= '0;
        end else begin
            state     <= next_state;
            dba_prev  <= dba;
            // A new rise on the device being accepted wins over its clear.
            pending   <= (pending & ~clr) | rise;
            pic_out_q <= pic_out_d;
            dev_ack_q <= dev_ack_d;
            sel       <= sel_d;
        end
    end

    assign bus.pic_out = pic_out_q;
    assign bus.dev_ack = dev_ack_q;
    assign bus.pend_o  = pending;

endmodule
`default_nettype wire
